opnd_fetch_16b: RTL and testbench

OPND_FETCH_16B -- requirements
Module: opnd_fetch_16b

---
 rtl/opnd_fetch_16b_pkg.sv | 16 +
 rtl/opnd_fetch_16b_regfile.sv | 34 +++
 rtl/opnd_fetch_16b.sv | 93 +++++++++
 tb/tb_opnd_fetch_16b.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/opnd_fetch_16b_pkg.sv
// Shared constants for the operand-fetch stage: datapath sizes and the
// logic-op encodings understood by the downstream bitwise unit.
package opnd_fetch_16b_pkg;

    localparam int OPND_WIDTH = 16;
    localparam int OPND_NREG  = 8;
    localparam int OPND_IDX_W = $clog2(OPND_NREG);

    typedef enum logic [1:0] {
        FN_AND = 2'b00,
        FN_OR  = 2'b01,
        FN_XOR = 2'b10,
        FN_NOT = 2'b11
    } funct_e;

endpackage

// File: rtl/opnd_fetch_16b_regfile.sv
// Architectural register file: two combinational read ports, one write port,
// r0 hardwired to zero (reads return 0, writes are dropped).
module regfile_8x16b #(
    parameter int WIDTH = 16,
    parameter int NREG  = 8,
    parameter int IW    = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IW-1:0]    ra1,
    output logic [WIDTH-1:0] rd1,
    input  logic [IW-1:0]    ra2,
    output logic [WIDTH-1:0] rd2,
    input  logic             we,
    input  logic [IW-1:0]    wa,
    input  logic [WIDTH-1:0] wd
);

    logic [WIDTH-1:0] mem [NREG];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (wa != '0)) begin
            mem[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == '0) ? '0 : mem[ra1];
    assign rd2 = (ra2 == '0) ? '0 : mem[ra2];

endmodule

// File: rtl/opnd_fetch_16b.sv
// Operand fetch stage: reads two source registers into a single-entry pipeline
// register feeding a bitwise unit, and writes the returned result back.
module opnd_fetch_16b
    import opnd_fetch_16b_pkg::*;
#(
    parameter int WIDTH = OPND_WIDTH,
    parameter int NREG  = OPND_NREG
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [OPND_IDX_W-1:0] in_rs,
    input  logic [OPND_IDX_W-1:0] in_rt,
    input  logic [OPND_IDX_W-1:0] in_rd,
    input  logic [1:0]            in_funct,
    output logic [WIDTH-1:0]      a,
    output logic [WIDTH-1:0]      b,
    output logic [1:0]            funct,
    input  logic [WIDTH-1:0]      res,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [15:0]           retired
);

    // Handshake: a transfer happens on a rising edge where valid && ready are
    // both high; valid, once raised, holds with its payload until ready.
    logic                  accept;
    logic                  retire;
    logic [WIDTH-1:0]      rf_a;
    logic [WIDTH-1:0]      rf_b;
    logic [WIDTH-1:0]      a_nxt;
    logic [WIDTH-1:0]      b_nxt;
    logic [WIDTH-1:0]      a_q;
    logic [WIDTH-1:0]      b_q;
    funct_e                funct_q;
    logic [OPND_IDX_W-1:0] rd_q;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign retire   = out_valid && out_ready;

    regfile_8x16b #(
        .WIDTH (WIDTH),
        .NREG  (NREG),
        .IW    (OPND_IDX_W)
    ) u_rf (
        .clk (clk),
        .rst (rst),
        .ra1 (in_rs),
        .rd1 (rf_a),
        .ra2 (in_rt),
        .rd2 (rf_b),
        .we  (retire),
        .wa  (rd_q),
        .wd  (res)
    );

    // The write of the retiring op lands on the same edge we sample the file,
    // so forward its result to any source that names its destination.
    always_comb begin
        a_nxt = rf_a;
        b_nxt = rf_b;
        if (retire && (rd_q != '0) && (in_rs == rd_q)) a_nxt = res;
        if (retire && (rd_q != '0) && (in_rt == rd_q)) b_nxt = res;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            funct_q   <= FN_AND;
            rd_q      <= '0;
            retired   <= '0;
        end else begin
            if (accept) begin
                a_q     <= a_nxt;
                b_q     <= b_nxt;
                funct_q <= funct_e'(in_funct);
                rd_q    <= in_rd;
            end
            if (accept)      out_valid <= 1'b1;
            else if (retire) out_valid <= 1'b0;
            if (retire) retired <= retired + 16'd1;
        end
    end

    assign a     = a_q;
    assign b     = b_q;
    assign funct = funct_q;

endmodule

// File: tb/tb_opnd_fetch_16b.sv
// Bench for opnd_fetch_16b: models the bitwise unit and the architectural
// register state, scoreboarding each op's operands as it retires.
module tb_opnd_fetch_16b;
    import opnd_fetch_16b_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_rs = '0;
    logic [2:0]  in_rt = '0;
    logic [2:0]  in_rd = '0;
    logic [1:0]  in_funct = '0;
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  funct;
    logic [15:0] res;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] retired;

    logic        force_en = 1'b0;
    logic [15:0] force_val = '0;
    logic [15:0] ref_r [8];
    logic [33:0] exp_q [$];
    logic [15:0] exp_retired = '0;
    int          n_cmp = 0;
    int          n_err = 0;

    opnd_fetch_16b dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rs     (in_rs),
        .in_rt     (in_rt),
        .in_rd     (in_rd),
        .in_funct  (in_funct),
        .a         (a),
        .b         (b),
        .funct     (funct),
        .res       (res),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .retired   (retired)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- bitwise unit model ----------------
    function automatic logic [15:0] bw(input logic [15:0] x, input logic [15:0] y,
                                       input logic [1:0] fn);
        case (fn)
            FN_AND:  return x & y;
            FN_OR:   return x | y;
            FN_XOR:  return x ^ y;
            default: return ~x;
        endcase
    endfunction

    assign res = force_en ? force_val : bw(a, b, funct);

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_underflow: got a=%h b=%h funct=%b with nothing expected", a, b, funct);
            end else begin
                logic [33:0] e;
                e = exp_q.pop_front();
                if ({a, b, funct} !== e) begin
                    n_err++;
                    $display("FAIL sb_operands: got a=%h b=%h funct=%b expected a=%h b=%h funct=%b",
                             a, b, funct, e[33:18], e[17:2], e[1:0]);
                end
            end
            exp_retired = exp_retired + 16'd1;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue_op(input logic [2:0] rs, input logic [2:0] rt,
                            input logic [2:0] rd, input logic [1:0] fn);
        int n;
        logic [15:0] ea, eb, er;
        in_rs = rs; in_rt = rt; in_rd = rd; in_funct = fn; in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            in_valid = 1'b0;
            n_cmp++; n_err++;
            $display("FAIL issue_timeout: in_ready=%b required=1", in_ready);
        end else begin
            ea = ref_r[rs];
            eb = ref_r[rt];
            er = force_en ? force_val : bw(ea, eb, fn);
            exp_q.push_back({ea, eb, fn});
            if (rd != 3'd0) ref_r[rd] = er;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (out_valid && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (out_valid) begin
            n_cmp++; n_err++;
            $display("FAIL drain_timeout: out_valid=%b required=0", out_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic load_reg(input logic [2:0] idx, input logic [15:0] v);
        force_en = 1'b1;
        force_val = v;
        issue_op(3'd0, 3'd0, idx, FN_OR);
        @(posedge clk); #1;
        force_en = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 8; i++) ref_r[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (retired !== 16'h0) begin n_err++; $display("FAIL reset_retired: got %h want 0000", retired); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_cmp++; if ({a, b, funct} !== 34'h0) begin n_err++; $display("FAIL reset_operands: got a=%h b=%h funct=%b want 0", a, b, funct); end
        rst = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) issue_op(3'(i), 3'(i), 3'd0, FN_AND);
        drain();
        n_cmp++; if (retired !== 16'd8) begin n_err++; $display("FAIL reset_reads_retired: got %h want 0008", retired); end
    endtask

    task automatic test_writeback();
        logic [15:0] pre;
        load_reg(3'd1, 16'h00F0);
        load_reg(3'd2, 16'h0FF0);
        drain();
        pre = exp_retired;
        issue_op(3'd1, 3'd2, 3'd3, FN_AND);
        n_cmp++; if ({a, b, funct} !== {16'h00F0, 16'h0FF0, 2'b00}) begin
            n_err++; $display("FAIL wb_operands: got a=%h b=%h funct=%b want 00f0 0ff0 00", a, b, funct);
        end
        drain();
        n_cmp++; if (retired !== pre + 16'd1) begin n_err++; $display("FAIL wb_retired: got %h want %h", retired, pre + 16'd1); end
        issue_op(3'd3, 3'd0, 3'd0, FN_OR);
        n_cmp++; if (a !== 16'h00F0) begin n_err++; $display("FAIL wb_r3_read: got %h want 00f0", a); end
        drain();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        issue_op(3'd1, 3'd2, 3'd4, FN_XOR);
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready: got %b want 1", in_ready); end
        issue_op(3'd4, 3'd1, 3'd5, FN_OR);
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_no_bubble: out_valid=%b want 1", out_valid); end
        n_cmp++; if (a !== 16'h0F00) begin n_err++; $display("FAIL b2b_bypass_a: got %h want 0f00", a); end
        issue_op(3'd5, 3'd4, 3'd0, FN_AND);
        n_cmp++; if ({a, b} !== {16'h0FF0, 16'h0F00}) begin n_err++; $display("FAIL b2b_chain: got a=%h b=%h want 0ff0 0f00", a, b); end
        drain();
    endtask

    task automatic test_stall();
        logic [15:0] pre;
        out_ready = 1'b0;
        issue_op(3'd1, 3'd2, 3'd6, FN_XOR);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready[%0d]: got %b want 0", i, in_ready); end
            n_cmp++; if ({a, b, funct} !== {16'h00F0, 16'h0FF0, 2'b10}) begin
                n_err++; $display("FAIL stall_hold[%0d]: got a=%h b=%h funct=%b want 00f0 0ff0 10", i, a, b, funct);
            end
        end
        @(posedge clk); #1;
        pre = exp_retired;
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++; if (retired !== pre + 16'd1) begin n_err++; $display("FAIL stall_retired: got %h want %h", retired, pre + 16'd1); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stall_release: out_valid=%b want 0", out_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_r0();
        logic [15:0] pre;
        pre = exp_retired;
        load_reg(3'd0, 16'hFFFF);
        drain();
        n_cmp++; if (retired !== pre + 16'd1) begin n_err++; $display("FAIL r0_retired: got %h want %h", retired, pre + 16'd1); end
        issue_op(3'd0, 3'd0, 3'd0, FN_OR);
        n_cmp++; if (a !== 16'h0000) begin n_err++; $display("FAIL r0_read: got %h want 0000", a); end
        drain();
    endtask

    task automatic test_wrap_and_reset();
        int cnt;
        cnt = 16'hFFFF - int'(exp_retired);
        for (int i = 0; i < cnt; i++) issue_op(3'(i % 8), 3'((i + 3) % 8), 3'd0, 2'(i % 4));
        drain();
        n_cmp++; if (retired !== 16'hFFFF) begin n_err++; $display("FAIL wrap_preset: got %h want ffff", retired); end
        issue_op(3'd2, 3'd1, 3'd0, FN_NOT);
        drain();
        n_cmp++; if (retired !== 16'h0000) begin n_err++; $display("FAIL wrap_rollover: got %h want 0000", retired); end
        // park an op that would write r7, then reset under it
        out_ready = 1'b0;
        issue_op(3'd1, 3'd2, 3'd7, FN_OR);
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
        n_cmp++; if ({a, b} !== 32'h0) begin n_err++; $display("FAIL midrst_operands: got a=%h b=%h want 0", a, b); end
        exp_q.delete();
        for (int i = 0; i < 8; i++) ref_r[i] = '0;
        exp_retired = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        issue_op(3'd7, 3'd1, 3'd0, FN_OR);
        n_cmp++; if ({a, b} !== 32'h0) begin n_err++; $display("FAIL midrst_no_write: got r7=%h r1=%h want 0", a, b); end
        drain();
        n_cmp++; if (retired !== 16'd1) begin n_err++; $display("FAIL midrst_retired: got %h want 0001", retired); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_writeback();
        test_back_to_back();
        test_stall();
        test_r0();
        test_wrap_and_reset();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL sb_leftover: %0d expected ops never retired, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
